// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared FSM states and parity-mode encodings for the UART RX.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Mode 2'b11 is reserved and behaves like PAR_NONE.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchroniser for an asynchronous, idle-high input.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Oversampling UART receiver with parity, framing and break handling.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int OS      = 16,
  parameter int SB_TICK = 16
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            rx_i,
  input  logic            tick_i,
  input  logic [1:0]      parity_mode_i,
  output logic [DBIT-1:0] dout_o,
  output logic            rx_done_o,
  output logic            parity_err_o,
  output logic            frame_err_o,
  output logic            busy_o
);

  localparam int SMAX = (OS > SB_TICK) ? OS : SB_TICK;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = $clog2(DBIT);

  localparam logic [SW-1:0] S_HALF = SW'(OS / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic            rxs;
  rx_state_e       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic [1:0]      pm_q, pm_d;
  logic            pbit_q, pbit_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;

  uart_rx_sync u_sync (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .d_i    (rx_i),
    .q_o    (rxs)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shreg_q <= '0;
      pm_q    <= PAR_NONE;
      pbit_q  <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shreg_q <= shreg_d;
      pm_q    <= pm_d;
      pbit_q  <= pbit_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shreg_d = shreg_q;
    pm_d    = pm_q;
    pbit_d  = pbit_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;

    unique case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          s_d     = '0;
          pm_d    = parity_mode_i;
        end
      end
      START: begin
        if (tick_i) begin
          if (s_q == S_HALF) begin
            // A line that is high again at mid start bit was only a glitch.
            if (!rxs) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (tick_i) begin
          if (s_q == S_BIT) begin
            s_d     = '0;
            shreg_d = {rxs, shreg_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = parity_enabled(pm_q) ? PARITY : STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      PARITY: begin
        if (tick_i) begin
          if (s_q == S_BIT) begin
            pbit_d  = rxs;
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (tick_i) begin
          if (s_q == S_STOP) begin
            dout_d  = shreg_q;
            done_d  = 1'b1;
            ferr_d  = ~rxs;
            unique case (pm_q)
              PAR_EVEN: perr_d = (^shreg_q) ^ pbit_q;
              PAR_ODD:  perr_d = ~((^shreg_q) ^ pbit_q);
              default:  perr_d = 1'b0;
            endcase
            state_d = rxs ? IDLE : BREAK_WAIT;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      BREAK_WAIT: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout_o       = dout_q;
  assign rx_done_o    = done_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign busy_o       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_param
// Description : Self-checking bench for uart_rx_param with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       rx = 1'b1;
  logic       rx2 = 1'b1;
  logic       tick = 1'b0;
  logic [1:0] pmode = 2'b00;
  logic [1:0] pmode2 = 2'b00;

  logic [7:0] dout;
  logic       done, perr, ferr, busy;
  logic [6:0] dout2;
  logic       done2, perr2, ferr2, busy2;

  int n_checks = 0;
  int n_pass   = 0;
  int tick_edges = 0;
  int done_cnt = 0, done_tick = 0;
  int done2_cnt = 0, done2_tick = 0;

  uart_rx_param #(.DBIT(8), .OS(16), .SB_TICK(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .rx_i(rx), .tick_i(tick),
    .parity_mode_i(pmode), .dout_o(dout), .rx_done_o(done),
    .parity_err_o(perr), .frame_err_o(ferr), .busy_o(busy)
  );

  uart_rx_param #(.DBIT(7), .OS(16), .SB_TICK(32)) dut2 (
    .clk_i(clk), .reset_i(reset_i), .rx_i(rx2), .tick_i(tick),
    .parity_mode_i(pmode2), .dout_o(dout2), .rx_done_o(done2),
    .parity_err_o(perr2), .frame_err_o(ferr2), .busy_o(busy2)
  );

  always #5 clk = ~clk;

  // One tick every 10 clocks, changed on the falling edge.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      ph   = (ph == 9) ? 0 : ph + 1;
      tick = (ph == 9);
    end
  end

  always @(posedge clk) if (tick) tick_edges++;

  always @(negedge clk) begin
    if (done)  begin done_cnt++;  done_tick  = tick_edges; end
    if (done2) begin done2_cnt++; done2_tick = tick_edges; end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!tick);
    end
    @(negedge clk);
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx = v;
    else rx2 = v;
  endtask

  // Drives one frame and compares the result with what the frame rules predict.
  task automatic send_frame(input int sel, input int nbits, input int sb,
                            input logic [8:0] data, input logic [1:0] pm,
                            input bit flip, input bit stopv, input bit sw_none);
    int  d0, t0, ones, exp_ticks;
    bit  par;
    logic pb;
    par  = (pm == 2'b01) || (pm == 2'b10);
    ones = 0;
    for (int i = 0; i < nbits; i++) ones += int'(data[i]);
    pb = (pm == 2'b01) ? logic'(ones % 2) : logic'(1 - ones % 2);
    pb = pb ^ flip;
    if (sel == 0) pmode = pm; else pmode2 = pm;
    d0 = (sel == 0) ? done_cnt : done2_cnt;
    t0 = tick_edges;
    set_line(sel, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < nbits; i++) begin
      set_line(sel, data[i]);
      if (sw_none && i == 3) pmode = 2'b00;
      wait_ticks(16);
    end
    if (par) begin
      set_line(sel, pb);
      wait_ticks(16);
    end
    set_line(sel, stopv);
    wait_ticks(sb);
    set_line(sel, 1'b1);
    wait_ticks(4);
    exp_ticks = 8 + nbits * 16 + (par ? 16 : 0) + sb;
    if (sel == 0) begin
      check("done_count", 32'(done_cnt - d0), 32'd1);
      check("done_tick", 32'(done_tick - t0), 32'(exp_ticks));
      check("dout", 32'(dout), 32'(data[7:0]));
      check("parity_err", 32'(perr), 32'(par && flip));
      check("frame_err", 32'(ferr), 32'(!stopv));
    end else begin
      check("done2_count", 32'(done2_cnt - d0), 32'd1);
      check("done2_tick", 32'(done2_tick - t0), 32'(exp_ticks));
      check("dout2", 32'(dout2), 32'(data[6:0]));
      check("frame_err2", 32'(ferr2), 32'(!stopv));
    end
  endtask

  initial begin
    int d0;
    repeat (5) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_perr", 32'(perr), 32'd0);
    check("rst_ferr", 32'(ferr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    wait_ticks(2);

    send_frame(0, 8, 16, 9'h0A5, 2'b00, 1'b0, 1'b1, 1'b0);
    send_frame(0, 8, 16, 9'h03C, 2'b01, 1'b0, 1'b1, 1'b0);
    send_frame(0, 8, 16, 9'h03C, 2'b01, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of data bit 4 discards the frame.
    pmode = 2'b00;
    d0 = done_cnt;
    set_line(0, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      set_line(0, 1'b0);
      wait_ticks(16);
    end
    wait_ticks(8);
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset_i = 1'b1;
    set_line(0, 1'b1);
    @(negedge clk);
    reset_i = 1'b0;
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_perr", 32'(perr), 32'd0);
    check("mid_rst_ferr", 32'(ferr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    wait_ticks(200);
    check("post_rst_no_done", 32'(done_cnt - d0), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    send_frame(0, 8, 16, 9'h001, 2'b10, 1'b0, 1'b1, 1'b1);

    // Start-bit glitch.
    pmode = 2'b00;
    d0 = done_cnt;
    set_line(0, 1'b0);
    wait_ticks(3);
    check("glitch_busy_hi", 32'(busy), 32'd1);
    set_line(0, 1'b1);
    wait_ticks(6);
    check("glitch_busy_lo", 32'(busy), 32'd0);
    check("glitch_no_done", 32'(done_cnt - d0), 32'd0);
    send_frame(0, 8, 16, 9'h05A, 2'b00, 1'b0, 1'b1, 1'b0);

    // Break: line held low for 20 bit times.
    d0 = done_cnt;
    set_line(0, 1'b0);
    wait_ticks(320);
    check("break_done_count", 32'(done_cnt - d0), 32'd1);
    check("break_dout", 32'(dout), 32'd0);
    check("break_ferr", 32'(ferr), 32'd1);
    check("break_busy", 32'(busy), 32'd1);
    set_line(0, 1'b1);
    wait_ticks(4);
    check("break_release_busy", 32'(busy), 32'd0);
    check("break_done_final", 32'(done_cnt - d0), 32'd1);
    send_frame(0, 8, 16, 9'h081, 2'b00, 1'b0, 1'b1, 1'b0);

    for (int k = 0; k < 12; k++) begin
      logic [8:0] rd;
      logic [1:0] rpm;
      bit rflip, rstop;
      rd    = 9'($urandom_range(0, 255));
      rpm   = 2'($urandom_range(0, 3));
      rflip = 1'($urandom_range(0, 1));
      rstop = ($urandom_range(0, 3) != 0);
      send_frame(0, 8, 16, rd, rpm, rflip, rstop, 1'b0);
    end

    send_frame(1, 7, 32, 9'h055, 2'b00, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed 8-bit receiver. Data width, oversampling ratio and stop length are set by parameters; parity mode (none/even/odd) is set at run time. Adds a 2-flop input synchroniser, start-bit glitch rejection, parity and framing error flags, and break handling. It sits between the baud-rate tick generator and the RX FIFO/interface logic.

Parameters:
DBIT, 8, data bits per frame (5..9), sent LSB first
OS, 16, ticks per bit (oversampling ratio, even, >=4)
SB_TICK, 16, ticks sampled for the stop bit (OS=1 stop, 1.5*OS=1.5 stop, 2*OS=2 stop)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx  in  1  serial line, asynchronous, idle high
tick  in  1  one-clk-wide pulse at OS x baud rate
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
dout  out  DBIT  last received data word
rx_done  out  1  one-clk pulse, frame complete
parity_err  out  1  parity mismatch on last frame
frame_err  out  1  stop bit sampled low on last frame
busy  out  1  high in any state except IDLE

Behaviour:
- One clock; reset is synchronous and active-high; all state updates on posedge clk.
- Reset values: dout=0, rx_done=0, parity_err=0, frame_err=0, busy=0, FSM=IDLE, sync flops=1, tick counter s=0, bit counter n=0.
- rx passes through a 2-flop synchroniser (rxs). All decisions use rxs, so the line-to-FSM latency is 2 clk.
- Counters: s counts ticks, width clog2(max(OS,SB_TICK)); n counts bits, width clog2(DBIT). Both advance only on clk edges where tick=1.
- FSM:
  - IDLE: when rxs=0, go to START, set s=0, latch parity_mode into pm_q. Later parity_mode changes have no effect on the current frame.
  - START: on each tick, s++. When s=OS/2-1, sample rxs. If rxs=0, go to DATA with s=0 and n=0. If rxs=1, it was a glitch: go to IDLE with no flags and no rx_done.
  - DATA: on each tick, s++. When s=OS-1, shift rxs into the MSB of shreg (right shift) and set s=0. If n=DBIT-1, go to PARITY when pm_q is even/odd, otherwise go to STOP. Else n++.
  - PARITY: when s=OS-1, store pbit=rxs and go to STOP with s=0.
  - STOP: when s=SB_TICK-1, sample rxs and, in the same clk:
    - dout<=shreg; rx_done<=1
    - frame_err<=~rxs
    - parity_err<=(pm_q even: ^shreg^pbit; odd: ~(^shreg^pbit); none: 0)
    - next state: BREAK_WAIT if rxs=0, else IDLE.
  - BREAK_WAIT: stay until rxs=1, then go to IDLE. This stops a held-low line from restarting frames.
- rx_done is high for exactly one clk per completed frame.
- dout and the error flags hold their values until the next rx_done and are never updated mid-frame.
- Sample point is mid-bit. Total ticks per frame = OS/2 + DBIT*OS + (parity?OS:0) + SB_TICK.
- When tick=0, no state or counter changes.
- reset asserted in any state forces the reset values on the next edge. A partial frame is discarded and no rx_done is produced.

Decomposition:
- Package uart_pkg:
  - FSM state encoding: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT
  - parity mode constants: PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10
- Sub-module uart_rx_sync: 2-flop synchroniser with reset value 1, reusable by other async inputs.

Test Plan:
- All tests: tick every 10 clk, DBIT=8, OS=16, SB_TICK=16.
- 0xA5 at 8N1 -> dout=8'hA5; exactly one rx_done pulse at 152 ticks (+2 clk) after the start edge; parity_err=0, frame_err=0.
- Even parity, 0x3C with parity bit 0 -> dout=8'h3C, parity_err=0. Same frame with parity bit 1 -> parity_err=1, dout=8'h3C.
- Odd parity, 0x01 with parity bit 0 -> parity_err=0. parity_mode switched to none mid-frame -> frame still parsed with parity.
- rx low for 3 ticks then high -> busy drops at the START check, no rx_done; a following valid 0x5A is received correctly.
- rx held low for 20 bit times -> one rx_done with dout=8'h00 and frame_err=1; no further rx_done until rx returns high; the next frame 0x81 is received correctly.
- reset pulse during DATA bit 4 -> all outputs 0, FSM IDLE, no rx_done. Separately, a DBIT=7, SB_TICK=32 instance given 7'h55 -> dout=7'h55.
